// File: rtl/eth_pkg.sv
// Shared Ethernet framing constants and the receive-framer state encoding.
package eth_pkg;

    localparam logic [7:0]  ETH_PREAMBLE  = 8'h55;
    localparam logic [7:0]  ETH_SFD       = 8'hD5;
    localparam logic [31:0] CRC32_POLY    = 32'hEDB88320;
    localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
    localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB20E3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PRE  = 2'd1,
        ST_DATA = 2'd2,
        ST_DROP = 2'd3
    } rx_state_e;

endpackage

// File: rtl/crc32_d8.sv
// Reflected CRC-32 advanced by one byte, LSB first; purely combinational.
module crc32_d8
    import eth_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [7:0]  data,
    output logic [31:0] crc_out
);

    always_comb begin
        crc_out = crc_in;
        for (int i = 0; i < 8; i++) begin
            if (crc_out[0] ^ data[i]) begin
                crc_out = (crc_out >> 1) ^ CRC32_POLY;
            end else begin
                crc_out = crc_out >> 1;
            end
        end
    end

endmodule

// File: rtl/gmii_rx_frame.sv
// GMII receive framer: strips preamble/SFD, checks FCS and length, drops the FCS
// and emits a sop/eop-marked byte stream with good/bad status and frame counters.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | between frames, waiting for the first preamble byte
// PRE     | inside preamble, waiting for SFD
// DATA    | frame body: count, CRC, hold 5 bytes, emit oldest
// DROP    | discarding the rest of a rejected frame until RX_DV drops
module gmii_rx_frame
    import eth_pkg::*;
#(
    parameter int MAX_LEN = 1518,
    parameter int MIN_LEN = 64
) (
    input  logic        rgmii_clk,
    input  logic        rst,
    input  logic        mac_rx_data_valid,
    input  logic [7:0]  mac_rx_data,
    input  logic        mac_rx_error,
    output logic        rx_valid,
    output logic [7:0]  rx_data,
    output logic        rx_sop,
    output logic        rx_eop,
    output logic        rx_good,
    output logic        rx_bad,
    output logic [15:0] good_cnt,
    output logic [15:0] bad_cnt
);

    localparam logic [10:0] MAX_LEN_L  = 11'(MAX_LEN);
    localparam logic [10:0] MIN_LEN_L  = 11'(MIN_LEN);
    localparam logic [10:0] OVER_LEN_L = 11'(MAX_LEN + 1);
    localparam logic [2:0]  HOLD_DEPTH = 3'd5;

    rx_state_e       state_q, state_d;
    logic [10:0]     len_q, len_d;
    logic [31:0]     crc_q, crc_d;
    logic [31:0]     crc_next;
    logic [4:0][7:0] hold_q, hold_d;
    logic [2:0]      hold_cnt_q, hold_cnt_d;
    logic            err_q, err_d;
    logic            first_q, first_d;

    logic            rx_valid_q, rx_valid_d;
    logic [7:0]      rx_data_q, rx_data_d;
    logic            rx_sop_q, rx_sop_d;
    logic            rx_eop_q, rx_eop_d;
    logic            rx_good_q, rx_good_d;
    logic            rx_bad_q, rx_bad_d;
    logic [15:0]     good_cnt_q, good_cnt_d;
    logic [15:0]     bad_cnt_q, bad_cnt_d;

    logic            count_good;
    logic            count_bad;
    logic            frame_ok;

    crc32_d8 u_crc (
        .crc_in  (crc_q),
        .data    (mac_rx_data),
        .crc_out (crc_next)
    );

    // The FCS bytes are already folded into crc_q when RX_DV drops.
    assign frame_ok = (crc_q == CRC32_RESIDUE) && (len_q >= MIN_LEN_L) &&
                      (len_q <= MAX_LEN_L) && !err_q;

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        crc_d      = crc_q;
        hold_d     = hold_q;
        hold_cnt_d = hold_cnt_q;
        err_d      = err_q;
        first_d    = first_q;
        rx_valid_d = 1'b0;
        rx_data_d  = rx_data_q;
        rx_sop_d   = 1'b0;
        rx_eop_d   = 1'b0;
        rx_good_d  = 1'b0;
        rx_bad_d   = 1'b0;
        count_good = 1'b0;
        count_bad  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (mac_rx_data_valid) begin
                    state_d = (mac_rx_data == ETH_PREAMBLE) ? ST_PRE : ST_DROP;
                end
            end

            ST_PRE: begin
                if (!mac_rx_data_valid) begin
                    state_d = ST_IDLE;
                end else if (mac_rx_error) begin
                    state_d = ST_DROP;
                end else if (mac_rx_data == ETH_SFD) begin
                    state_d    = ST_DATA;
                    len_d      = '0;
                    crc_d      = CRC32_INIT;
                    hold_d     = '0;
                    hold_cnt_d = '0;
                    err_d      = 1'b0;
                    first_d    = 1'b1;
                end else if (mac_rx_data != ETH_PREAMBLE) begin
                    state_d = ST_DROP;
                end
            end

            ST_DATA: begin
                if (mac_rx_data_valid) begin
                    len_d  = len_q + 11'd1;
                    crc_d  = crc_next;
                    hold_d = {hold_q[3:0], mac_rx_data};
                    err_d  = err_q | mac_rx_error;
                    if (hold_cnt_q == HOLD_DEPTH) begin
                        rx_valid_d = 1'b1;
                        rx_data_d  = hold_q[4];
                        rx_sop_d   = first_q;
                        first_d    = 1'b0;
                    end else begin
                        hold_cnt_d = hold_cnt_q + 3'd1;
                    end
                    // Hold is always full here because MAX_LEN is well above 5.
                    if (len_d == OVER_LEN_L) begin
                        rx_eop_d  = 1'b1;
                        rx_bad_d  = 1'b1;
                        count_bad = 1'b1;
                        state_d   = ST_DROP;
                    end
                end else begin
                    state_d = ST_IDLE;
                    if (hold_cnt_q == HOLD_DEPTH) begin
                        rx_valid_d = 1'b1;
                        rx_data_d  = hold_q[4];
                        rx_sop_d   = first_q;
                        rx_eop_d   = 1'b1;
                        rx_good_d  = frame_ok;
                        rx_bad_d   = !frame_ok;
                        count_good = frame_ok;
                        count_bad  = !frame_ok;
                    end else begin
                        count_bad = 1'b1;
                    end
                end
            end

            ST_DROP: begin
                if (!mac_rx_data_valid) begin
                    state_d = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase

        good_cnt_d = good_cnt_q;
        bad_cnt_d  = bad_cnt_q;
        if (count_good && (good_cnt_q != 16'hFFFF)) begin
            good_cnt_d = good_cnt_q + 16'd1;
        end
        if (count_bad && (bad_cnt_q != 16'hFFFF)) begin
            bad_cnt_d = bad_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge rgmii_clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            len_q      <= '0;
            crc_q      <= '0;
            hold_q     <= '0;
            hold_cnt_q <= '0;
            err_q      <= 1'b0;
            first_q    <= 1'b0;
            rx_valid_q <= 1'b0;
            rx_data_q  <= '0;
            rx_sop_q   <= 1'b0;
            rx_eop_q   <= 1'b0;
            rx_good_q  <= 1'b0;
            rx_bad_q   <= 1'b0;
            good_cnt_q <= '0;
            bad_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            crc_q      <= crc_d;
            hold_q     <= hold_d;
            hold_cnt_q <= hold_cnt_d;
            err_q      <= err_d;
            first_q    <= first_d;
            rx_valid_q <= rx_valid_d;
            rx_data_q  <= rx_data_d;
            rx_sop_q   <= rx_sop_d;
            rx_eop_q   <= rx_eop_d;
            rx_good_q  <= rx_good_d;
            rx_bad_q   <= rx_bad_d;
            good_cnt_q <= good_cnt_d;
            bad_cnt_q  <= bad_cnt_d;
        end
    end

    assign rx_valid = rx_valid_q;
    assign rx_data  = rx_data_q;
    assign rx_sop   = rx_sop_q;
    assign rx_eop   = rx_eop_q;
    assign rx_good  = rx_good_q;
    assign rx_bad   = rx_bad_q;
    assign good_cnt = good_cnt_q;
    assign bad_cnt  = bad_cnt_q;

endmodule

// File: tb/tb_gmii_rx_frame.sv
// Bench for gmii_rx_frame: directed frame table, reset-mid-frame sequence and
// random frames scored against a frame-level reference model.
module tb_gmii_rx_frame;

    localparam int MAX_LEN = 1518;
    localparam int MIN_LEN = 64;

    logic        rgmii_clk = 1'b0;
    logic        rst = 1'b1;
    logic        dv = 1'b0;
    logic [7:0]  rxd = 8'h00;
    logic        er = 1'b0;
    logic        rx_valid, rx_sop, rx_eop, rx_good, rx_bad;
    logic [7:0]  rx_data;
    logic [15:0] good_cnt, bad_cnt;

    always #4 rgmii_clk = ~rgmii_clk;

    gmii_rx_frame #(.MAX_LEN(MAX_LEN), .MIN_LEN(MIN_LEN)) dut (
        .rgmii_clk         (rgmii_clk),
        .rst               (rst),
        .mac_rx_data_valid (dv),
        .mac_rx_data       (rxd),
        .mac_rx_error      (er),
        .rx_valid          (rx_valid),
        .rx_data           (rx_data),
        .rx_sop            (rx_sop),
        .rx_eop            (rx_eop),
        .rx_good           (rx_good),
        .rx_bad            (rx_bad),
        .good_cnt          (good_cnt),
        .bad_cnt           (bad_cnt)
    );

    typedef struct packed {
        logic [7:0] d;
        logic       sop;
        logic       eop;
        logic       good;
        logic       bad;
    } out_t;

    typedef struct {
        int n_pay;
        bit add_fcs;
        bit flip_fcs;
        int err_idx;
        bit bad_pre;
        int exp_n;
        int exp_dgood;
        int exp_dbad;
    } vec_t;

    out_t       exp_q[$];
    logic [7:0] body[$];
    int         n_vec = 0;
    int         n_err = 0;
    int         good_m = 0;
    int         bad_m = 0;
    out_t       got_m, exp_m;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, req);
        end
    endtask

    always @(negedge rgmii_clk) begin
        if (rx_valid === 1'b1) begin
            got_m = {rx_data, rx_sop, rx_eop, rx_good, rx_bad};
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_byte: got {d,sop,eop,good,bad}=0x%0h, want no output", got_m);
            end else begin
                exp_m = exp_q.pop_front();
                check("out_byte{d,sop,eop,good,bad}", 32'(got_m), 32'(exp_m));
            end
        end
    end

    // Plain CRC-32 over body[0..n-1]; returns the FCS value (complemented register).
    function automatic logic [31:0] fcs_of(input int n);
        logic [31:0] c;
        c = 32'hFFFFFFFF;
        for (int i = 0; i < n; i++) begin
            c = c ^ {24'h0, body[i]};
            for (int b = 0; b < 8; b++) begin
                c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
            end
        end
        return ~c;
    endfunction

    task automatic make_body(input int n_pay, input bit add_fcs, input bit flip);
        logic [31:0] f;
        body.delete();
        for (int i = 0; i < n_pay; i++) body.push_back(8'($urandom_range(0, 255)));
        if (add_fcs) begin
            f = fcs_of(n_pay);
            body.push_back(f[7:0]);
            body.push_back(f[15:8]);
            body.push_back(f[23:16]);
            body.push_back(f[31:24]);
        end
        if (flip && body.size() > 0) body[body.size()-1] = body[body.size()-1] ^ 8'h10;
    endtask

    task automatic push_exp(input int n, input bit good);
        out_t r;
        for (int i = 0; i < n; i++) begin
            r.d    = body[i];
            r.sop  = (i == 0);
            r.eop  = (i == n - 1);
            r.good = good && (i == n - 1);
            r.bad  = !good && (i == n - 1);
            exp_q.push_back(r);
        end
    endtask

    // Frame-level expectation: how many bytes come out and whether the frame is good.
    task automatic model(input int err_idx, output int n, output bit good);
        int N;
        bit err_seen;
        logic [31:0] rx_fcs;
        N = body.size();
        err_seen = (err_idx >= 0) && (err_idx < N);
        if (N < 5) begin
            n = 0;
            good = 1'b0;
        end else if (N > MAX_LEN) begin
            n = MAX_LEN - 4;
            good = 1'b0;
        end else begin
            n = N - 4;
            rx_fcs = {body[N-1], body[N-2], body[N-3], body[N-4]};
            good = (fcs_of(N - 4) == rx_fcs) && (N >= MIN_LEN) && !err_seen;
        end
    endtask

    task automatic send(input logic [7:0] d, input logic e);
        @(negedge rgmii_clk);
        dv = 1'b1;
        rxd = d;
        er = e;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge rgmii_clk);
            dv = 1'b0;
            rxd = 8'h00;
            er = 1'b0;
        end
    endtask

    task automatic drive_frame(input int pre_len, input bit bad_pre, input int err_idx, input int gap);
        for (int i = 0; i < pre_len; i++) send((bad_pre && i == 2) ? 8'h54 : 8'h55, 1'b0);
        send(8'hD5, 1'b0);
        for (int i = 0; i < body.size(); i++) send(body[i], (i == err_idx));
        idle(gap);
    endtask

    task automatic drain(input string tag);
        idle(10);
        #1;
        check({tag, ":pending_bytes"}, 32'(exp_q.size()), 32'd0);
        check({tag, ":good_cnt"}, 32'(good_cnt), 32'(good_m));
        check({tag, ":bad_cnt"}, 32'(bad_cnt), 32'(bad_m));
    endtask

    vec_t tbl[12];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "timeout");
    end

    initial begin
        int  n;
        bit  good;
        int  n_pay, err_idx;
        logic [31:0] f;

        //           n_pay fcs flip err  badpre exp_n dgood dbad
        tbl[0]  = '{60,   1,  0,   -1,  0,     60,   1,    0};
        tbl[1]  = '{60,   1,  1,   -1,  0,     60,   0,    1};
        tbl[2]  = '{3,    0,  0,   -1,  0,     0,    0,    1};
        tbl[3]  = '{1600, 0,  0,   -1,  0,     1514, 0,    1};
        tbl[4]  = '{60,   1,  0,   -1,  0,     60,   1,    0};
        tbl[5]  = '{60,   1,  0,   20,  0,     60,   0,    1};
        tbl[6]  = '{60,   1,  0,   -1,  1,     0,    0,    0};
        tbl[7]  = '{59,   1,  0,   -1,  0,     59,   0,    1};
        tbl[8]  = '{1514, 1,  0,   -1,  0,     1514, 1,    0};
        tbl[9]  = '{1515, 1,  0,   -1,  0,     1514, 0,    1};
        tbl[10] = '{4,    0,  0,   -1,  0,     0,    0,    1};
        tbl[11] = '{0,    0,  0,   -1,  0,     0,    0,    1};

        rst = 1'b1;
        repeat (4) @(negedge rgmii_clk);
        #1;
        check("reset:rx_valid", 32'(rx_valid), 32'd0);
        check("reset:rx_eop", 32'(rx_eop), 32'd0);
        check("reset:good_cnt", 32'(good_cnt), 32'd0);
        check("reset:bad_cnt", 32'(bad_cnt), 32'd0);
        @(negedge rgmii_clk);
        rst = 1'b0;
        idle(2);

        for (int t = 0; t < 12; t++) begin
            make_body(tbl[t].n_pay, tbl[t].add_fcs, tbl[t].flip_fcs);
            if (tbl[t].exp_n > 0) push_exp(tbl[t].exp_n, tbl[t].exp_dgood != 0);
            good_m += tbl[t].exp_dgood;
            bad_m  += tbl[t].exp_dbad;
            drive_frame(7, tbl[t].bad_pre, tbl[t].err_idx, 2);
            drain($sformatf("table%0d", t));
        end

        // Reset asserted for two cycles at payload byte 30 with RX_DV held high.
        body.delete();
        for (int i = 0; i < 60; i++) body.push_back(8'(i));
        f = fcs_of(60);
        body.push_back(f[7:0]);
        body.push_back(f[15:8]);
        body.push_back(f[23:16]);
        body.push_back(f[31:24]);
        push_exp(25, 1'b0);
        for (int i = 0; i < 25; i++) exp_q[exp_q.size()-25+i].eop = 1'b0;
        exp_q[exp_q.size()-1].bad = 1'b0;
        for (int i = 0; i < 7; i++) send(8'h55, 1'b0);
        send(8'hD5, 1'b0);
        for (int i = 0; i < body.size(); i++) begin
            send(body[i], 1'b0);
            if (i == 30) rst = 1'b1;
            if (i == 32) rst = 1'b0;
        end
        idle(2);
        good_m = 0;
        bad_m  = 0;
        drain("reset_mid_frame");

        make_body(60, 1'b1, 1'b0);
        push_exp(60, 1'b1);
        good_m++;
        drive_frame(7, 1'b0, -1, 2);
        drain("after_reset_good");
        check("after_reset:good_cnt_is_1", 32'(good_cnt), 32'd1);

        for (int k = 0; k < 40; k++) begin
            n_pay = ((k % 10) == 9) ? $urandom_range(1505, 1525) : $urandom_range(0, 100);
            make_body(n_pay, ($urandom_range(0, 9) != 0), ($urandom_range(0, 3) == 0));
            err_idx = ($urandom_range(0, 6) == 0) ? $urandom_range(0, n_pay + 3) : -1;
            model(err_idx, n, good);
            if (n > 0) push_exp(n, good);
            if (good) good_m++;
            else bad_m++;
            drive_frame($urandom_range(1, 7), 1'b0, err_idx, $urandom_range(1, 3));
        end
        drain("random");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
